cla_pipelined_seg: RTL and testbench

Segmented, pipelined W-bit adder/subtractor with a valid/ready handshake and stall-capable pipeline. It is the parametrised successor to the team's fixed-latency pipelined adder. The carry chain is split into S segments of W/S bits, one segment per pipeline stage, so per-stage logic depth scales with W/S rather than W. The block also adds subtract mode, carry-out and signed-overflow flags, a sideband tag and output backpressure. It sits between operand producers and any consumer that can stall.

---
 rtl/cla_pipelined_seg.sv | 119 +++++++++++
 tb/tb_cla_pipelined_seg.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipelined_seg.sv
// Segmented pipelined adder/subtractor: one SEG-bit carry segment per stage,
// valid/ready handshake with a single global advance that stalls the whole pipe.
module cla_pipelined_seg #(
    parameter int W  = 128,
    parameter int S  = 4,
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sub,
    input  logic [W-1:0]  in_op1,
    input  logic [W-1:0]  in_op2,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_sum,
    output logic          out_cout,
    output logic          out_ovf,
    output logic [TW-1:0] out_tag
);
    localparam int SEG = W / S;

    logic w_adv;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    genvar gi;
    generate
        for (gi = 0; gi < S; gi++) begin : g_stage
            // Operand bits still to be added when entering this stage.
            localparam int OP_W = W - gi * SEG;

            logic                    w_v_in;
            logic                    w_c_in;
            logic [TW-1:0]           w_tag_in;
            logic [OP_W-1:0]         w_a_in;
            logic [OP_W-1:0]         w_b_in;
            logic [SEG:0]            w_seg;
            logic [(gi+1)*SEG-1:0]   w_sum_next;

            logic                    r_v;
            logic                    r_c;
            logic [TW-1:0]           r_tag;
            logic [(gi+1)*SEG-1:0]   r_sum;

            assign w_seg = {1'b0, w_a_in[SEG-1:0]} + {1'b0, w_b_in[SEG-1:0]}
                         + {{SEG{1'b0}}, w_c_in};

            if (gi == 0) begin : g_src
                // Bubbles enter as all-zero data so idle outputs read as zero.
                assign w_v_in     = in_valid;
                assign w_c_in     = in_valid & in_sub;
                assign w_tag_in   = in_valid ? in_tag : '0;
                assign w_a_in     = in_valid ? in_op1 : '0;
                assign w_b_in     = in_valid ? (in_sub ? ~in_op2 : in_op2) : '0;
                assign w_sum_next = w_seg[SEG-1:0];
            end else begin : g_src
                assign w_v_in     = g_stage[gi-1].r_v;
                assign w_c_in     = g_stage[gi-1].r_c;
                assign w_tag_in   = g_stage[gi-1].r_tag;
                assign w_a_in     = g_stage[gi-1].g_opnd.r_a;
                assign w_b_in     = g_stage[gi-1].g_opnd.r_b;
                assign w_sum_next = {w_seg[SEG-1:0], g_stage[gi-1].r_sum};
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v   <= 1'b0;
                    r_c   <= 1'b0;
                    r_tag <= '0;
                    r_sum <= '0;
                end else if (w_adv) begin
                    r_v   <= w_v_in;
                    r_c   <= w_seg[SEG];
                    r_tag <= w_tag_in;
                    r_sum <= w_sum_next;
                end
            end

            if (gi < S - 1) begin : g_opnd
                // Only the not-yet-consumed upper segments travel onward.
                logic [OP_W-SEG-1:0] r_a;
                logic [OP_W-SEG-1:0] r_b;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_adv) begin
                        r_a <= w_a_in[OP_W-1:SEG];
                        r_b <= w_b_in[OP_W-1:SEG];
                    end
                end
            end else begin : g_top
                logic r_ovf;

                // Carry-in XOR carry-out of the MSB, expressed via operand/result signs.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_ovf <= 1'b0;
                    end else if (w_adv) begin
                        r_ovf <= (w_a_in[OP_W-1] == w_b_in[OP_W-1])
                               & (w_seg[SEG-1] ^ w_a_in[OP_W-1]);
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[S-1].r_v;
    assign out_sum   = g_stage[S-1].r_sum;
    assign out_cout  = g_stage[S-1].r_c;
    assign out_ovf   = g_stage[S-1].g_top.r_ovf;
    assign out_tag   = g_stage[S-1].r_tag;

endmodule

// File: tb/tb_cla_pipelined_seg.sv
// Bench for cla_pipelined_seg: directed vectors, streaming, backpressure,
// bubbles and async reset, with a queue scoreboard checking every result.
module tb_cla_pipelined_seg;
    localparam int W  = 128;
    localparam int S  = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_sub;
    logic [W-1:0]  in_op1;
    logic [W-1:0]  in_op2;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic [TW-1:0] out_tag;

    cla_pipelined_seg #(.W(W), .S(S), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sub    (in_sub),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct {
        logic          sub;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        logic [W-1:0]  sum;
        logic          cout;
        logic          ovf;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   alt      = 1'b0;
    bit   vp[16];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic sub, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [TW-1:0] tag);
        exp_t       e;
        logic [W:0] full;
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            e.ovf  = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
        end else begin
            full   = {1'b0, a} + {1'b0, b};
            e.sum  = full[W-1:0];
            e.cout = full[W];
            e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        end
        e.tag = tag;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard: inputs and outputs are stable at the falling edge and
    // describe what the next rising edge will accept / consume.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_underflow: got result tag %0d expected none (t=%0t)", out_tag, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_sum", out_sum, mon_e.sum);
                    chk("sb_flags", {out_cout, out_ovf, out_tag}, {mon_e.cout, mon_e.ovf, mon_e.tag});
                    $display("result tag=%0d sum=%h cout=%0b ovf=%0b", out_tag, out_sum, out_cout, out_ovf);
                end
            end
            if (!out_valid) begin
                chk("idle_sum", out_sum, '0);
                chk("idle_flags", {out_cout, out_ovf, out_tag}, '0);
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_sub, in_op1, in_op2, in_tag));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (alt) out_ready = ~out_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        in_valid = 1'b0;
        in_sub   = 1'b0;
        in_op1   = rnd128();
        in_op2   = rnd128();
        in_tag   = TW'($urandom());
    endtask

    // Presents a beat and holds it until accepted; returns at posedge+1.
    task automatic send_beat(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [TW-1:0] tag, output int waited);
        bit acc = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        in_sub   = sub;
        in_op1   = a;
        in_op2   = b;
        in_tag   = tag;
        while (!acc && waited < 64) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        chk("accept_bound", acc, 1);
        $display("sent tag=%0d sub=%0b after %0d cycles", tag, sub, waited);
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while ((sb.size() != 0 || out_valid) && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic run_vec(input vec_t v);
        in_valid = 1'b1;
        in_sub   = v.sub;
        in_op1   = v.a;
        in_op2   = v.b;
        in_tag   = v.tag;
        @(posedge clk);
        #1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("vec_early", out_valid, 0);
        @(posedge clk);
        #1;
        chk("vec_valid", out_valid, 1);
        chk("vec_sum", out_sum, v.sum);
        chk("vec_cout", out_cout, v.cout);
        chk("vec_ovf", out_ovf, v.ovf);
        chk("vec_tag", out_tag, v.tag);
        $display("vector tag=%0d sum=%h cout=%0b ovf=%0b", v.tag, out_sum, out_cout, out_ovf);
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] smax;
        logic [W-1:0] smin;
        int           w;

        ones = {W{1'b1}};
        smax = {1'b0, {(W-1){1'b1}}};
        smin = {1'b1, {(W-1){1'b0}}};
        vecs[0] = '{1'b0, ones,         128'd1,      4'd3, 128'd0,       1'b1, 1'b0};
        vecs[1] = '{1'b1, 128'd5,       128'd7,      4'd1, ones - 128'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, smax,         128'd1,      4'd2, smin,         1'b0, 1'b1};
        vecs[3] = '{1'b1, smin,         128'd1,      4'd4, smax,         1'b1, 1'b1};
        vecs[4] = '{1'b1, 128'd7,       128'd5,      4'd5, 128'd2,       1'b1, 1'b0};
        vecs[5] = '{1'b0, smin,         smin,        4'd6, 128'd0,       1'b1, 1'b1};
        vecs[6] = '{1'b1, 128'd0,       128'd0,      4'd7, 128'd0,       1'b1, 1'b0};
        vecs[7] = '{1'b0, 128'hFFFFFFFF, 128'd1,     4'd8, 128'h100000000, 1'b0, 1'b0};

        rst       = 1'b1;
        out_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, '0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        drain();

        // Back-to-back streaming with tags 0..7.
        for (int i = 0; i < 8; i++) begin
            send_beat(1'($urandom()), rnd128(), rnd128(), TW'(i), w);
            chk("stream_nostall", w, 1);
            chk("stream_in_ready", in_ready, 1);
            if (i >= 3) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_tag", out_tag, TW'(i - 3));
            end
        end
        idle();
        for (int j = 5; j < 8; j++) begin
            @(posedge clk);
            #1;
            chk("stream_tail_tag", out_tag, TW'(j));
        end
        @(posedge clk);
        #1;
        chk("stream_end_valid", out_valid, 0);

        // Full pipe, then three stalled cycles with a pending input beat.
        for (int i = 0; i < 4; i++) send_beat(1'($urandom()), rnd128(), rnd128(), TW'(i), w);
        in_valid  = 1'b1;
        in_sub    = 1'b0;
        in_op1    = rnd128();
        in_op2    = rnd128();
        in_tag    = 4'd9;
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_hold_sum", out_sum, sb[0].sum);
            chk("bp_hold_tag", out_tag, sb[0].tag);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        drain();

        // Alternating consumer readiness.
        alt = 1'b1;
        for (int i = 0; i < 12; i++) send_beat(1'($urandom()), rnd128(), rnd128(), TW'(i), w);
        drain();
        alt       = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Bubbles every other cycle, with garbage on the data inputs.
        for (int k = 0; k < 14; k++) begin
            in_valid = (k < 10) ? ((k % 2) == 0) : 1'b0;
            in_sub   = 1'($urandom());
            in_op1   = rnd128();
            in_op2   = rnd128();
            in_tag   = TW'(k);
            vp[k]    = in_valid;
            @(posedge clk);
            #1;
            chk("bub_in_ready", in_ready, 1);
            if (k >= 3) chk("bub_valid", out_valid, vp[k-3]);
        end
        drain();

        // Asynchronous reset between edges with a full pipe.
        for (int i = 0; i < 5; i++) send_beat(1'($urandom()), rnd128(), rnd128(), TW'(i), w);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_sum", out_sum, '0);
        chk("arst_flags", {out_cout, out_ovf, out_tag}, '0);
        chk("arst_in_ready", in_ready, 1);
        sb.delete();
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_vec(vecs[3]);
        drain();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("arst_no_stale", out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
